// File: rtl/adsr_pkg.sv
// Shared types for the ADSR envelope generator: state encoding and its width.
package adsr_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } adsr_state_e;

endpackage

// File: rtl/adsr_envelope_tick_gen.sv
// Tick prescaler: free-running counter that pulses o_tick when it reaches i_div,
// counting only while enabled; a synchronous clear restarts the period.
module tick_gen #(
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [DIV_BITS-1:0] i_div,
  output logic                o_tick
);

  logic [DIV_BITS-1:0] r_cnt;
  logic                w_hit;

  assign w_hit  = (r_cnt == i_div);
  // A clear in the same cycle wins, so the coinciding tick is dropped.
  assign o_tick = i_en & ~i_clr & w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate edge detect, A/D/S/R state machine and saturating
// per-tick amplitude arithmetic driving the PWM duty input.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int RES      = 8,
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gate,
  input  logic [DIV_BITS-1:0] tick_div,
  input  logic [RES-1:0]      attack_step,
  input  logic [RES-1:0]      decay_step,
  input  logic [RES-1:0]      sustain_level,
  input  logic [RES-1:0]      release_step,
  output logic [RES-1:0]      env_out,
  output logic                active,
  output logic [STATE_W-1:0]  state_out
);

  localparam logic [RES-1:0] MAX = '1;

  adsr_state_e  r_state;
  logic [RES-1:0] r_env;
  logic           r_gate_q;

  logic           w_rise;
  logic           w_fall;
  logic           w_fall_act;
  logic           w_edge;
  logic           w_tick;
  logic [RES:0]   w_att_sum;
  logic [RES:0]   w_dec_floor;
  logic           w_att_done;
  logic           w_dec_done;
  logic           w_rel_done;

  assign w_rise     = gate & ~r_gate_q;
  assign w_fall     = ~gate & r_gate_q;
  // Release only makes sense from a sounding, key-held state.
  assign w_fall_act = w_fall & ((r_state == S_ATTACK) ||
                                (r_state == S_DECAY)  ||
                                (r_state == S_SUSTAIN));
  assign w_edge     = w_rise | w_fall_act;

  tick_gen #(
    .DIV_BITS (DIV_BITS)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state != S_IDLE),
    .i_clr  (w_edge),
    .i_div  (tick_div),
    .o_tick (w_tick)
  );

  // One extra bit so the attack sum and decay floor never wrap.
  assign w_att_sum   = {1'b0, r_env} + {1'b0, attack_step};
  assign w_dec_floor = {1'b0, sustain_level} + {1'b0, decay_step};
  assign w_att_done  = (attack_step == '0) || (w_att_sum >= {1'b0, MAX});
  assign w_dec_done  = (decay_step == '0) || ({1'b0, r_env} <= w_dec_floor);
  assign w_rel_done  = (release_step == '0) || (r_env <= release_step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_env    <= '0;
      r_gate_q <= 1'b0;
    end else begin
      r_gate_q <= gate;
      if (w_rise) begin
        r_state <= S_ATTACK;
      end else if (w_fall_act) begin
        r_state <= S_RELEASE;
      end else if (w_tick) begin
        unique case (r_state)
          S_ATTACK: begin
            if (w_att_done) begin
              r_env   <= MAX;
              r_state <= S_DECAY;
            end else begin
              r_env   <= w_att_sum[RES-1:0];
            end
          end
          S_DECAY: begin
            if (w_dec_done) begin
              r_env   <= sustain_level;
              r_state <= S_SUSTAIN;
            end else begin
              r_env   <= r_env - decay_step;
            end
          end
          S_SUSTAIN: r_env <= sustain_level;
          S_RELEASE: begin
            if (w_rel_done) begin
              r_env   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_env   <= r_env - release_step;
            end
          end
          default: r_env <= '0;
        endcase
      end
    end
  end

  assign env_out   = r_env;
  assign state_out = r_state;
  assign active    = (r_state != S_IDLE);

endmodule
